event_readout_ctrl: RTL and testbench
=====================================

Name: event_readout_ctrl

Overview:
- Reader side of the event buffer whose occupancy memory_monitor tracks.
- While n_pileup is non-zero, it fetches one fixed-length event from the sample RAM and streams it out over a valid/ready interface.
- After the event's last word is accepted downstream, it pulses read_complete, which is the decrement input of memory_monitor.
- Sits between the event RAM read port and the OFC-I output serializer.

Parameters:
- WORDS_PER_EVENT, 64: samples per event; must be ≥ 2 and ≤ 2^ADDR_W.
- ADDR_W, 10: event RAM address width.
- DATA_W, 16: sample width.
- RAM_LATENCY, 2: cycles from ram_rd_en to valid ram_rd_data; range 1 to 4.
- FIFO_DEPTH, 4: output skid FIFO depth; must be ≥ RAM_LATENCY+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- live_rising  in  1  run-start pulse; synchronous flush
- n_pileup  in  6  unread event count from memory_monitor, unsigned
- read_overflow  in  1  overflow flag from memory_monitor
- ram_rd_en  out  1  RAM read strobe
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data, valid RAM_LATENCY cycles after ram_rd_en
- tx_data  out  DATA_W  output word
- tx_valid  out  1  output word valid
- tx_ready  in  1  downstream accept
- tx_sof  out  1  first word of event, qualified by tx_valid
- tx_eof  out  1  last word of event, qualified by tx_valid
- read_complete  out  1  one-cycle pulse per event fully transmitted
- busy  out  1  high in any state other than IDLE
- evt_count  out  16  events completed since run start

Behaviour:
Reset:
- On rst_n low, asynchronously: all outputs 0, state IDLE, rd_ptr = 0, FIFO empty, in-flight tags cleared.

States:
- IDLE: go to FETCH when n_pileup != 0 and read_overflow == 0. Latch base = rd_ptr; clear word counter.
- FETCH: issue one read per cycle when (fifo_count + inflight) < FIFO_DEPTH.
  - ram_rd_addr = base + word_idx, modulo 2^ADDR_W.
  - Issue exactly WORDS_PER_EVENT reads, then go to DRAIN.
- DRAIN: wait until inflight == 0, the FIFO is empty, and the eof word has been handshaken. Then go to DONE.
- DONE: read_complete = 1 for exactly this cycle; evt_count += 1, wrapping at 2^16; rd_ptr += WORDS_PER_EVENT, wrapping. Next state is IDLE.

Timing and flow control:
- memory_monitor updates n_pileup on the edge that samples read_complete, so IDLE sees the decremented value on the next cycle. No extra gap state is needed.
- Each issued read carries a RAM_LATENCY-deep valid shift tag. A tagged word is written into the FIFO on arrival. The credit rule guarantees the FIFO never overflows, so no data is ever dropped under backpressure.
- The FIFO head drives tx_data, tx_valid, tx_sof and tx_eof.
- A word is transferred when tx_valid & tx_ready are both high in the same cycle.
- While tx_valid=1 and tx_ready=0, tx_data, tx_sof and tx_eof hold stable.
- With tx_ready held at 1, steady-state throughput is one word per cycle. First-word latency from leaving IDLE is RAM_LATENCY+1 cycles.
- sof/eof are tagged at issue time: word_idx 0 is sof, word_idx WORDS_PER_EVENT-1 is eof.

Boundary conditions:
- live_rising (any state, synchronous): state→IDLE, rd_ptr=0, FIFO cleared, in-flight tags cleared, tx_valid=0, evt_count=0, no read_complete. Any partial event is abandoned.
- read_overflow=1: no new event starts. An event already in progress completes normally.
- n_pileup is treated as unsigned; any non-zero value, including 63, starts a read. The block never issues read_complete without a completed event, so it cannot cause underflow itself.
- Address wrap: an event that spans the top of the address space continues at address 0 with no gap.
- tx_ready=0 for an arbitrarily long time: reads stall by credit, and no word is lost or duplicated.
- n_pileup rising during FETCH or DRAIN has no effect until the next IDLE.

Test Plan:
1. WORDS_PER_EVENT=8, RAM at address a holds data=a, n_pileup held at 1, tx_ready=1 → words 0..7 on consecutive cycles; sof on word 0, eof on word 7. One read_complete one cycle after the eof handshake, evt_count=1. If n_pileup is then driven to 0, the block stays IDLE.
2. n_pileup=3, decremented by a bench model of memory_monitor → three back-to-back events at base addresses 0, 8 and 16, three read_complete pulses, evt_count=3, then busy=0.
3. tx_ready toggled randomly at 30% duty during an event → exactly 8 words in order with no duplicates, data held stable while stalled, and the FIFO never exceeds FIFO_DEPTH.
4. ADDR_W=4, rd_ptr preloaded to 12 by completing 12 words (e.g. WORDS_PER_EVENT=4, three events), then a fourth event → addresses 12, 13, 14, 15 and rd_ptr wraps to 0. A further event reads 0..3.
5. live_rising at the 4th word of an event → tx_valid=0 next cycle, no read_complete, evt_count=0, rd_ptr=0. With n_pileup=1 after the flush, the next event starts at address 0.
6. read_overflow=1 with n_pileup=5 → no ram_rd_en. Raising read_overflow mid-event lets that event finish with one read_complete; asserting rst_n=0 mid-event clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/event_readout_ctrl.sv
// event_readout_ctrl
//
// Reader side of the event buffer. Whenever the occupancy monitor reports at
// least one unread event (n_pileup != 0) and no overflow, one fixed-length
// event of WORDS_PER_EVENT samples is fetched from the event RAM and streamed
// out on a valid/ready interface. When the last word of the event has been
// accepted downstream, read_complete pulses once. That pulse is the decrement
// input of the occupancy monitor.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   live_rising            run-start pulse; synchronous flush of all state
//   n_pileup[5:0]          unread event count (unsigned)
//   read_overflow          blocks the start of new events
//   ram_rd_en/ram_rd_addr  RAM read strobe and address
//   ram_rd_data            RAM data, valid RAM_LATENCY cycles after ram_rd_en
//   tx_data/tx_valid/tx_ready/tx_sof/tx_eof   output stream
//   read_complete          one-cycle pulse per fully transmitted event
//   busy                   high in any state other than IDLE
//   evt_count[15:0]        events completed since run start
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for n_pileup != 0 with read_overflow low
// FETCH | issuing RAM reads while skid FIFO credit allows
// DRAIN | all reads issued; waiting for the eof word handshake
// DONE  | pulse read_complete, bump evt_count, advance rd_ptr

module event_readout_ctrl #(
    parameter int WORDS_PER_EVENT = 64,
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 16,
    parameter int RAM_LATENCY     = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              live_rising,
    input  logic [5:0]        n_pileup,
    input  logic              read_overflow,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              read_complete,
    output logic              busy,
    output logic [15:0]       evt_count
);

    localparam int IDX_W = $clog2(WORDS_PER_EVENT + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_EVENT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   base;
    logic [IDX_W-1:0]    word_idx;

    // One tag slot per pipeline stage of the RAM; slot RAM_LATENCY-1 lines up
    // with valid ram_rd_data.
    logic [RAM_LATENCY-1:0] tag_v;
    logic [RAM_LATENCY-1:0] tag_sof;
    logic [RAM_LATENCY-1:0] tag_eof;

    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_sof;
    logic [FIFO_DEPTH-1:0] fifo_eof;
    logic [PTR_W-1:0]    fifo_head;
    logic [PTR_W-1:0]    fifo_tail;
    logic [CNT_W-1:0]    fifo_count;

    logic [CNT_W-1:0]    inflight;
    logic                credit_ok;
    logic                issue;
    logic                push;
    logic                pop;
    logic                eof_hs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_v[i]);
        end
    end

    // Credit counts words already in the FIFO plus words still in the RAM
    // pipeline, so every issued read has a guaranteed FIFO slot on arrival.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue     = (state == ST_FETCH) && credit_ok && !live_rising;
    assign push      = tag_v[RAM_LATENCY-1];
    assign tx_valid  = (fifo_count != '0);
    assign pop       = tx_valid && tx_ready;
    assign eof_hs    = pop && fifo_eof[fifo_head];

    assign tx_data   = tx_valid ? fifo_data[fifo_head] : '0;
    assign tx_sof    = tx_valid && fifo_sof[fifo_head];
    assign tx_eof    = tx_valid && fifo_eof[fifo_head];

    assign ram_rd_en     = issue;
    assign ram_rd_addr   = base + ADDR_W'(word_idx);
    assign read_complete = (state == ST_DONE) && !live_rising;
    assign busy          = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if ((n_pileup != 6'd0) && !read_overflow) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (issue && (word_idx == LAST_IDX)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The eof word is the last one issued, so its handshake means
                // the pipeline and FIFO are empty once this cycle ends.
                if (eof_hs && (inflight == '0)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (live_rising) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            base      <= '0;
            word_idx  <= '0;
            evt_count <= '0;
            tag_v     <= '0;
            tag_sof   <= '0;
            tag_eof   <= '0;
        end else begin
            state <= state_nxt;

            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_sof[i] <= tag_sof[i-1];
                tag_eof[i] <= tag_eof[i-1];
            end
            tag_v[0]   <= issue;
            tag_sof[0] <= (word_idx == '0);
            tag_eof[0] <= (word_idx == LAST_IDX);

            if ((state == ST_IDLE) && (state_nxt == ST_FETCH)) begin
                base     <= rd_ptr;
                word_idx <= '0;
            end else if (issue) begin
                word_idx <= word_idx + 1'b1;
            end

            if (state == ST_DONE) begin
                evt_count <= evt_count + 16'd1;
                rd_ptr    <= rd_ptr + ADDR_W'(WORDS_PER_EVENT);
            end

            if (live_rising) begin
                tag_v     <= '0;
                rd_ptr    <= '0;
                base      <= '0;
                word_idx  <= '0;
                evt_count <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= '0;
        end else if (live_rising) begin
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= '0;
        end else begin
            if (push) fifo_tail <= ptr_inc(fifo_tail);
            if (pop)  fifo_head <= ptr_inc(fifo_head);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while fifo_count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[fifo_tail] <= ram_rd_data;
            fifo_sof[fifo_tail]  <= tag_sof[RAM_LATENCY-1];
            fifo_eof[fifo_tail]  <= tag_eof[RAM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_event_readout_ctrl.sv
module tb_event_readout_ctrl;

    localparam int WPE   = 6;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          live_rising = 1'b0;
    logic [5:0]    n_pileup;
    logic          read_overflow = 1'b0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          tx_sof;
    logic          tx_eof;
    logic          read_complete;
    logic          busy;
    logic [15:0]   evt_count;

    int vectors = 0;
    int miscompares = 0;

    event_readout_ctrl #(
        .WORDS_PER_EVENT(WPE),
        .ADDR_W(AW),
        .DATA_W(DW),
        .RAM_LATENCY(LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .live_rising(live_rising),
        .n_pileup(n_pileup),
        .read_overflow(read_overflow),
        .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_sof(tx_sof),
        .tx_eof(tx_eof),
        .read_complete(read_complete),
        .busy(busy),
        .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    // Occupancy monitor model: n_pileup drops on the edge that samples read_complete.
    int rc_total = 0;
    int rc_mark  = 0;
    int np_set   = 0;
    bit mm_track = 1'b0;
    always @(posedge clk) if (read_complete) rc_total <= rc_total + 1;
    always_comb n_pileup = 6'(mm_track ? (np_set - (rc_total - rc_mark)) : np_set);

    // Event RAM model: word at address a is 16'hA000 | a, two-cycle latency.
    logic          v1 = 1'b0, v2 = 1'b0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        v1 <= ram_rd_en;
        a1 <= ram_rd_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign ram_rd_data = v2 ? (16'hA000 | {12'h000, a2}) : 16'hDEAD;

    // Passive monitor: handshakes, reads, pulses, stall stability.
    int            cyc = 0;
    logic [17:0]   hs_q[$];
    int            hs_cyc[$];
    logic [AW-1:0] addr_q[$];
    int            rd_cyc[$];
    int            rc_cyc[$];
    int            stall_viol = 0;
    logic          prev_stall = 1'b0;
    logic [17:0]   prev_word = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) begin
            hs_q.push_back({tx_sof, tx_eof, tx_data});
            hs_cyc.push_back(cyc);
        end
        if (ram_rd_en) begin
            addr_q.push_back(ram_rd_addr);
            rd_cyc.push_back(cyc);
        end
        if (read_complete) rc_cyc.push_back(cyc);
        if (prev_stall && (!tx_valid || ({tx_sof, tx_eof, tx_data} != prev_word)))
            stall_viol <= stall_viol + 1;
        prev_stall <= tx_valid && !tx_ready;
        prev_word  <= {tx_sof, tx_eof, tx_data};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rc(input string tag, input int budget);
        int k = 0;
        while (!read_complete && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, read_complete}, 32'd1);
    endtask

    task automatic check_event(input string tag, input int start, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        logic [17:0]   exp;
        chk({tag, "_present"}, {31'd0, hs_q.size() >= start + WPE}, 32'd1);
        for (int k = 0; k < WPE; k++) begin
            if (start + k < hs_q.size()) begin
                a   = base + AW'(k);
                exp = {k == 0, k == WPE - 1, 16'hA000 | {12'h000, a}};
                chk($sformatf("%s_w%0d", tag, k), {14'd0, hs_q[start + k]}, {14'd0, exp});
            end
        end
    endtask

    function automatic int at_cyc(input int which, input int idx);
        if (which == 0) return (idx >= 0 && idx < hs_cyc.size()) ? hs_cyc[idx] : -1000;
        if (which == 1) return (idx >= 0 && idx < rd_cyc.size()) ? rd_cyc[idx] : -1000;
        return (idx >= 0 && idx < rc_cyc.size()) ? rc_cyc[idx] : -1000;
    endfunction

    initial begin
        int hs_b, rd_b, rc_b, k;
        logic [AW-1:0] ea;

        // Reset state
        step(2);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd_en", {31'd0, ram_rd_en}, 0);
        chk("rst_rc", {31'd0, read_complete}, 0);
        chk("rst_evt", {16'd0, evt_count}, 0);
        chk("rst_addr", {28'd0, ram_rd_addr}, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_np0_busy", {31'd0, busy}, 0);

        // T1: single event from address 0, tx_ready high
        hs_b = hs_q.size(); rd_b = addr_q.size();
        rc_mark = rc_total; mm_track = 1'b1; np_set = 1;
        wait_rc("t1_rc_seen", 60);
        step(1);
        chk("t1_evt", {16'd0, evt_count}, 1);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_np", {26'd0, n_pileup}, 0);
        check_event("t1", hs_b, 4'd0);
        chk("t1_latency", 32'(at_cyc(0, hs_b) - at_cyc(1, rd_b)), 3);
        chk("t1_back2back", 32'(at_cyc(0, hs_b + WPE - 1) - at_cyc(0, hs_b)), WPE - 1);
        chk("t1_rc_after_eof", 32'(at_cyc(2, rc_cyc.size() - 1) - at_cyc(0, hs_b + WPE - 1)), 1);
        step(5);
        chk("t1_stay_idle", {31'd0, busy}, 0);
        chk("t1_reads", 32'(addr_q.size() - rd_b), WPE);

        // T2: three queued events, bases 6, 12 (wraps past 15), 2
        hs_b = hs_q.size(); rd_b = addr_q.size(); rc_b = rc_total;
        rc_mark = rc_total; np_set = 3;
        for (int e = 0; e < 3; e++) begin
            wait_rc($sformatf("t2_rc%0d_seen", e), 60);
            step(1);
        end
        chk("t2_rc_count", 32'(rc_total - rc_b), 3);
        chk("t2_evt", {16'd0, evt_count}, 4);
        chk("t2_busy", {31'd0, busy}, 0);
        chk("t2_words", 32'(hs_q.size() - hs_b), 3 * WPE);
        chk("t2_reads", 32'(addr_q.size() - rd_b), 3 * WPE);
        for (int i = 0; i < 3 * WPE; i++) begin
            ea = AW'(6 + i);
            if (rd_b + i < addr_q.size())
                chk($sformatf("t2_addr%0d", i), {28'd0, addr_q[rd_b + i]}, {28'd0, ea});
        end
        check_event("t2e0", hs_b, 4'd6);
        check_event("t2e1", hs_b + WPE, 4'd12);
        check_event("t2e2", hs_b + 2 * WPE, 4'd2);

        // T3: random backpressure at ~30% ready
        hs_b = hs_q.size();
        rc_mark = rc_total; np_set = 1;
        k = 0;
        while (!read_complete && k < 400) begin
            tx_ready = ($urandom_range(0, 99) < 30);
            @(negedge clk);
            k++;
        end
        chk("t3_rc_seen", {31'd0, read_complete}, 1);
        tx_ready = 1'b1;
        step(1);
        chk("t3_words", 32'(hs_q.size() - hs_b), WPE);
        check_event("t3", hs_b, 4'd8);
        chk("t3_stall_stable", 32'(stall_viol), 0);
        chk("t3_evt", {16'd0, evt_count}, 5);

        // T4: long stall; reads must stop at FIFO credit, then event spans 14..3
        hs_b = hs_q.size(); rd_b = addr_q.size();
        tx_ready = 1'b0;
        rc_mark = rc_total; np_set = 1;
        step(30);
        chk("t4_credit_reads", 32'(addr_q.size() - rd_b), DEPTH);
        chk("t4_valid_held", {31'd0, tx_valid}, 1);
        chk("t4_sof_held", {31'd0, tx_sof}, 1);
        chk("t4_no_hs", 32'(hs_q.size() - hs_b), 0);
        tx_ready = 1'b1;
        wait_rc("t4_rc_seen", 60);
        step(1);
        chk("t4_words", 32'(hs_q.size() - hs_b), WPE);
        check_event("t4", hs_b, 4'd14);
        chk("t4_stall_stable", 32'(stall_viol), 0);
        chk("t4_evt", {16'd0, evt_count}, 6);

        // T5: live_rising while the 4th word is presented
        hs_b = hs_q.size(); rc_b = rc_total;
        rc_mark = rc_total; np_set = 1;
        k = 0;
        while ((hs_q.size() - hs_b) < 3 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_w3", 32'(hs_q.size() - hs_b), 3);
        live_rising = 1'b1;
        step(1);
        live_rising = 1'b0;
        chk("t5_valid_cleared", {31'd0, tx_valid}, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_evt_cleared", {16'd0, evt_count}, 0);
        chk("t5_no_rc", 32'(rc_total - rc_b), 0);
        hs_b = hs_q.size(); rd_b = addr_q.size();
        wait_rc("t5_rc_seen", 60);
        step(1);
        chk("t5_restart_addr", (rd_b < addr_q.size()) ? {28'd0, addr_q[rd_b]} : 32'hFFFF, 0);
        chk("t5_words", 32'(hs_q.size() - hs_b), WPE);
        check_event("t5", hs_b, 4'd0);
        chk("t5_evt", {16'd0, evt_count}, 1);

        // T6: read_overflow blocks starts, not an event in progress
        rd_b = addr_q.size();
        read_overflow = 1'b1;
        mm_track = 1'b1; rc_mark = rc_total; np_set = 5;
        step(20);
        chk("t6_blocked_reads", 32'(addr_q.size() - rd_b), 0);
        chk("t6_blocked_busy", {31'd0, busy}, 0);
        hs_b = hs_q.size(); rc_b = rc_total;
        read_overflow = 1'b0;
        step(3);
        read_overflow = 1'b1;
        chk("t6_inflight_busy", {31'd0, busy}, 1);
        wait_rc("t6_rc_seen", 60);
        step(1);
        chk("t6_rc_count", 32'(rc_total - rc_b), 1);
        chk("t6_evt", {16'd0, evt_count}, 2);
        check_event("t6", hs_b, 4'd6);
        rd_b = addr_q.size();
        step(10);
        chk("t6_hold_busy", {31'd0, busy}, 0);
        chk("t6_hold_np", {26'd0, n_pileup}, 4);
        chk("t6_hold_reads", 32'(addr_q.size() - rd_b), 0);

        // Asynchronous reset in the middle of an event
        hs_b = hs_q.size();
        read_overflow = 1'b0;
        k = 0;
        while ((hs_q.size() - hs_b) < 2 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("t6_mid_event", {31'd0, tx_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", {31'd0, tx_valid}, 0);
        chk("arst_tx_data", {16'd0, tx_data}, 0);
        chk("arst_sof_eof", {30'd0, tx_sof, tx_eof}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_rd_en", {31'd0, ram_rd_en}, 0);
        chk("arst_rc", {31'd0, read_complete}, 0);
        chk("arst_evt", {16'd0, evt_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
